// File: rtl/ejector_pkg.sv
// Shared constants for the ejector router-port selector.
// Optional YX routing order is selected with the EJECTOR_YX_EN macro.
package ejector_pkg;

  localparam int DIR_NUM = 5;

  localparam int DIR_W = 0;
  localparam int DIR_E = 1;
  localparam int DIR_S = 2;
  localparam int DIR_N = 3;
  localparam int DIR_L = 4;

  typedef logic [DIR_NUM-1:0] dir_t;

endpackage

// File: rtl/ejector_route_calc.sv
// Combinational dimension-order route decision (XY, or YX under EJECTOR_YX_EN).
// Produces a one-hot output-port vector from a destination address.
module ejector_route_calc
  import ejector_pkg::*;
#(
  parameter int LOCAL_X = 4,
  parameter int LOCAL_Y = 4,
  parameter int ADDR_W  = 6
) (
  input  logic [ADDR_W-1:0] addr_i,
  output dir_t              dir_o
);

  localparam int CW = ADDR_W / 2;
  localparam logic [CW-1:0] LX = CW'(LOCAL_X);
  localparam logic [CW-1:0] LY = CW'(LOCAL_Y);

  logic [CW-1:0] dx;
  logic [CW-1:0] dy;
  logic x_gt, x_lt, y_gt, y_lt;

  assign dx   = addr_i[CW-1:0];
  assign dy   = addr_i[ADDR_W-1:CW];
  assign x_gt = dx > LX;
  assign x_lt = dx < LX;
  assign y_gt = dy > LY;
  assign y_lt = dy < LY;

  // Overlapping conditions are legal; first match sets the priority.
  always_comb begin
    dir_o = '0;
`ifdef EJECTOR_YX_EN
    priority case (1'b1)
      y_gt:    dir_o[DIR_N] = 1'b1;
      y_lt:    dir_o[DIR_S] = 1'b1;
      x_gt:    dir_o[DIR_E] = 1'b1;
      x_lt:    dir_o[DIR_W] = 1'b1;
      default: dir_o[DIR_L] = 1'b1;
    endcase
`else
    priority case (1'b1)
      x_gt:    dir_o[DIR_E] = 1'b1;
      x_lt:    dir_o[DIR_W] = 1'b1;
      y_gt:    dir_o[DIR_N] = 1'b1;
      y_lt:    dir_o[DIR_S] = 1'b1;
      default: dir_o[DIR_L] = 1'b1;
    endcase
`endif
  end

endmodule

// File: rtl/ejector.sv
// Registered router port selector: one-cycle route decision per header.
// Define EJECTOR_YX_EN to resolve Y before X.
module ejector
  import ejector_pkg::*;
#(
  parameter int LOCAL_X = 4,
  parameter int LOCAL_Y = 4,
  parameter int ADDR_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic [ADDR_W-1:0] addr,
  output logic [DIR_NUM-1:0] direct,
  output logic              direct_valid
);

  dir_t route;
  dir_t direct_d, direct_q;
  logic valid_d, valid_q;

  ejector_route_calc #(
    .LOCAL_X (LOCAL_X),
    .LOCAL_Y (LOCAL_Y),
    .ADDR_W  (ADDR_W)
  ) u_calc (
    .addr_i (addr),
    .dir_o  (route)
  );

  always_comb begin
    direct_d = valid ? route : '0;
    valid_d  = valid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      direct_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      direct_q <= direct_d;
      valid_q  <= valid_d;
    end
  end

  assign direct       = direct_q;
  assign direct_valid = valid_q;

endmodule

// File: tb/tb_ejector.sv
// Directed self-checking bench for ejector (LOCAL_X = LOCAL_Y = 4).
// Expected routes follow EJECTOR_YX_EN when the macro is defined.
module tb_ejector;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid;
  logic [5:0] addr;
  logic [4:0] direct;
  logic       direct_valid;

  int errors = 0;
  int checks = 0;

  localparam logic [4:0] W = 5'b00001;
  localparam logic [4:0] E = 5'b00010;
  localparam logic [4:0] S = 5'b00100;
  localparam logic [4:0] N = 5'b01000;
  localparam logic [4:0] L = 5'b10000;
  localparam logic [4:0] Z = 5'b00000;

  ejector #(
    .LOCAL_X (4),
    .LOCAL_Y (4),
    .ADDR_W  (6)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .valid        (valid),
    .addr         (addr),
    .direct       (direct),
    .direct_valid (direct_valid)
  );

  always #5 clk = ~clk;

  task automatic step(input string tag, input logic r, input logic v,
                      input logic [5:0] a, input logic [4:0] exp_d,
                      input logic exp_v);
    rst   = r;
    valid = v;
    addr  = a;
    @(posedge clk);
    #1;
    checks++;
    assert (direct === exp_d)
    else begin
      errors++;
      $error("FAIL %s direct: got %b expected %b", tag, direct, exp_d);
    end
    checks++;
    assert (direct_valid === exp_v)
    else begin
      errors++;
      $error("FAIL %s direct_valid: got %b expected %b", tag,
             direct_valid, exp_v);
    end
  endtask

  initial begin
    rst   = 1'b1;
    valid = 1'b0;
    addr  = '0;
    @(posedge clk);
    #1;
    step("reset_over_valid", 1'b1, 1'b1, 6'b100101, Z, 1'b0);
    step("first_after_rst",  1'b0, 1'b1, 6'b100101, E, 1'b1);
    step("west",             1'b0, 1'b1, 6'b100001, W, 1'b1);
    step("north",            1'b0, 1'b1, 6'b110100, N, 1'b1);
    step("south",            1'b0, 1'b1, 6'b000100, S, 1'b1);
    step("local",            1'b0, 1'b1, 6'b100100, L, 1'b1);
`ifdef EJECTOR_YX_EN
    step("diag_yx",          1'b0, 1'b1, 6'b110101, N, 1'b1);
`else
    step("diag_xy",          1'b0, 1'b1, 6'b110101, E, 1'b1);
`endif
    step("idle",             1'b0, 1'b0, 6'b100101, Z, 1'b0);
`ifdef EJECTOR_YX_EN
    step("b2b_origin",       1'b0, 1'b1, 6'b000000, S, 1'b1);
    step("b2b_max",          1'b0, 1'b1, 6'b111111, N, 1'b1);
`else
    step("b2b_origin",       1'b0, 1'b1, 6'b000000, W, 1'b1);
    step("b2b_max",          1'b0, 1'b1, 6'b111111, E, 1'b1);
`endif
    step("b2b_xmax",         1'b0, 1'b1, 6'b100111, E, 1'b1);
    step("b2b_ylo",          1'b0, 1'b1, 6'b011100, S, 1'b1);
    step("b2b_yhi",          1'b0, 1'b1, 6'b111100, N, 1'b1);
    step("b2b_xlo",          1'b0, 1'b1, 6'b100011, W, 1'b1);
    step("b2b_local",        1'b0, 1'b1, 6'b100100, L, 1'b1);
    step("mid_reset",        1'b1, 1'b1, 6'b100101, Z, 1'b0);
    step("idle_after_rst",   1'b0, 1'b0, 6'b110100, Z, 1'b0);
    step("resume",           1'b0, 1'b1, 6'b100001, W, 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
